// File: rtl/quad_enc_if.sv
// Bus bundle for quad_enc: sample strobe, raw phases, clear pulses and the
// position/status outputs read back over SPI.
interface quad_enc_if #(
    parameter int unsigned W = 16
);
    logic         en;
    logic         a;
    logic         b;
    logic         idx;
    logic         clr;
    logic         idx_clr;
    logic         err_clr;
    logic [W-1:0] count;
    logic [W-1:0] idx_pos;
    logic         idx_flag;
    logic         err;

    modport master (
        output en, a, b, idx, clr, idx_clr, err_clr,
        input  count, idx_pos, idx_flag, err
    );

    modport slave (
        input  en, a, b, idx, clr, idx_clr, err_clr,
        output count, idx_pos, idx_flag, err
    );
endinterface

// File: rtl/quad_enc.sv
// Quadrature decoder with index capture and sticky illegal-transition flag.
// Define QUAD_ENC_FILTER_EN to add an FLT-sample stability filter on A, B, idx.
module quad_enc #(
    parameter int unsigned W   = 16,
    parameter int unsigned FLT = 3
) (
    input logic       clk,
    input logic       rst_n,
    quad_enc_if.slave bus
);

    if ((FLT == 0) || (FLT > 15)) begin : g_flt_check
        $error("quad_enc: FLT must be in 1..15");
    end

    logic [1:0]   a_sync_q, b_sync_q, idx_sync_q;
    logic [2:0]   raw;
    logic [2:0]   filt_q, filt_d;
    logic         primed_q;
    logic         sample;
    logic [1:0]   prev_pos, cur_pos, delta;
    logic         idx_rise;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] idx_pos_q, idx_pos_d;
    logic         idx_flag_q, idx_flag_d;
    logic         err_q, err_d;

    // Synchronizers run every clk regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q   <= '0;
            b_sync_q   <= '0;
            idx_sync_q <= '0;
        end else begin
            a_sync_q   <= {a_sync_q[0], bus.a};
            b_sync_q   <= {b_sync_q[0], bus.b};
            idx_sync_q <= {idx_sync_q[0], bus.idx};
        end
    end

    assign raw = {a_sync_q[1], b_sync_q[1], idx_sync_q[1]};

`ifdef QUAD_ENC_FILTER_EN
    localparam logic [4:0] FltW = 5'(FLT);

    logic [2:0][3:0] run_q, run_d;

    // A bit adopts the synchronized value only after FLT consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        run_d  = run_q;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != filt_q[i]) begin
                if (({1'b0, run_q[i]} + 5'd1) >= FltW) begin
                    filt_d[i] = raw[i];
                    run_d[i]  = '0;
                end else begin
                    run_d[i] = run_q[i] + 4'd1;
                end
            end else begin
                run_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else if (bus.en) begin
            run_q <= primed_q ? run_d : '0;
        end
    end
`else
    assign filt_d = raw;
`endif

    assign sample   = bus.en & primed_q;
    // Gray {a,b} to a 2-bit phase: 00->0, 01->1, 11->2, 10->3.
    assign prev_pos = {filt_q[2], filt_q[2] ^ filt_q[1]};
    assign cur_pos  = {filt_d[2], filt_d[2] ^ filt_d[1]};
    assign delta    = cur_pos - prev_pos;
    assign idx_rise = filt_d[0] & ~filt_q[0];

    // Clears are applied first so a coincident set wins; clr overrides any step.
    always_comb begin
        count_d    = count_q;
        idx_pos_d  = idx_pos_q;
        idx_flag_d = idx_flag_q;
        err_d      = err_q;
        if (bus.idx_clr) idx_flag_d = 1'b0;
        if (bus.err_clr) err_d = 1'b0;
        if (sample) begin
            case (delta)
                2'd1:    count_d = count_q + W'(1);
                2'd3:    count_d = count_q - W'(1);
                2'd2:    err_d = 1'b1;
                default: ;
            endcase
            if (idx_rise) begin
                idx_pos_d  = count_q;
                idx_flag_d = 1'b1;
            end
        end
        if (bus.clr) count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= '0;
            primed_q   <= 1'b0;
            count_q    <= '0;
            idx_pos_q  <= '0;
            idx_flag_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (bus.en) begin
                filt_q   <= primed_q ? filt_d : raw;
                primed_q <= 1'b1;
            end
            count_q    <= count_d;
            idx_pos_q  <= idx_pos_d;
            idx_flag_q <= idx_flag_d;
            err_q      <= err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.idx_pos  = idx_pos_q;
    assign bus.idx_flag = idx_flag_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_quad_enc.sv
// Randomized and directed bench for quad_enc against a phase-arithmetic reference model.
module tb_quad_enc;
    localparam int unsigned W    = 16;
    localparam int unsigned FLT  = 3;
    localparam int          MASK = (1 << W) - 1;
`ifdef QUAD_ENC_FILTER_EN
    localparam int H = FLT;
`else
    localparam int H = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    quad_enc_if #(.W(W)) bus ();

    quad_enc #(.W(W), .FLT(FLT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    bit         m_primed;
    logic [1:0] m_ab;
    logic       m_idx;
    int         m_count;
    int         m_pos;
    bit         m_flag;
    bit         m_err;
`ifdef QUAD_ENC_FILTER_EN
    logic [2:0] m_filt;
    int         m_run[3];
`endif
    int         ph;

    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        m_primed = 0; m_ab = 2'b00; m_idx = 1'b0; m_count = 0;
        m_pos = 0; m_flag = 0; m_err = 0;
`ifdef QUAD_ENC_FILTER_EN
        m_filt = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
`endif
    endtask

    task automatic model_sample(input logic [2:0] rawv, input bit clr, input bit iclr,
                                input bit eclr);
        logic [2:0] f;
        bit set_idx, set_err;
        int d;
        set_idx = 0; set_err = 0; d = 0;
`ifdef QUAD_ENC_FILTER_EN
        if (!m_primed) begin
            m_filt = rawv;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rawv[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= int'(FLT)) begin
                        m_filt[i] = rawv[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        f = m_filt;
`else
        f = rawv;
`endif
        if (m_primed) begin
            d = (phase_of(f[2:1]) - phase_of(m_ab) + 4) % 4;
            set_err = (d == 2);
            set_idx = f[0] && !m_idx;
            if (set_idx) m_pos = m_count;
            if (d == 1) m_count = m_count + 1;
            if (d == 3) m_count = m_count - 1;
        end
        m_ab = f[2:1];
        m_idx = f[0];
        m_primed = 1;
        m_flag = set_idx ? 1'b1 : (iclr ? 1'b0 : m_flag);
        m_err  = set_err ? 1'b1 : (eclr ? 1'b0 : m_err);
        if (clr) m_count = 0;
        m_count = m_count & MASK;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".count"}, 32'(bus.count), m_count);
        check_val({tag, ".idx_pos"}, 32'(bus.idx_pos), m_pos);
        check_val({tag, ".idx_flag"}, 32'(bus.idx_flag), 32'(m_flag));
        check_val({tag, ".err"}, 32'(bus.err), 32'(m_err));
    endtask

    // Called and returns at a negedge; inputs settle through the synchronizers before en.
    task automatic do_sample(input string tag, input logic [1:0] ab, input logic ix,
                             input bit clr, input bit iclr, input bit eclr);
        bus.a = ab[1]; bus.b = ab[0]; bus.idx = ix;
        @(negedge clk);
        @(negedge clk);
        bus.en = 1'b1; bus.clr = clr; bus.idx_clr = iclr; bus.err_clr = eclr;
        @(negedge clk);
        bus.en = 1'b0; bus.clr = 1'b0; bus.idx_clr = 1'b0; bus.err_clr = 1'b0;
        model_sample({ab, ix}, clr, iclr, eclr);
        compare_all(tag);
    endtask

    task automatic move(input string tag, input int dir, input int holds);
        ph = (ph + dir + 4) % 4;
        for (int k = 0; k < holds; k++) do_sample(tag, ab_of(ph), 1'b0, 0, 0, 0);
    endtask

    initial begin
        bus.en = 0; bus.a = 0; bus.b = 0; bus.idx = 0;
        bus.clr = 0; bus.idx_clr = 0; bus.err_clr = 0;
        rst_n = 1'b0;
        ph = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare_all("reset");
        check_val("reset.count0", 32'(bus.count), 0);

        // Prime, then 8 forward steps each held 4 samples.
        do_sample("prime", 2'b00, 1'b0, 0, 0, 0);
        for (int s = 0; s < 8; s++) move("fwd8", 1, 4);
        check_val("fwd8.count", 32'(bus.count), 8);
        check_val("fwd8.err", 32'(bus.err), 0);

        // Reverse from zero wraps to all ones.
        do_sample("clr0", ab_of(ph), 1'b0, 1, 0, 0);
        move("rev_wrap", -1, H);
        check_val("rev_wrap.count", 32'(bus.count), 32'hFFFF);

        // Illegal jumps and err_clr precedence.
        move("to00", 1, H);
        ph = 2;
        for (int k = 0; k < H; k++) do_sample("jump00_11", 2'b11, 1'b0, 0, 0, 0);
        check_val("jump00_11.count", 32'(bus.count), 0);
        check_val("jump00_11.err", 32'(bus.err), 1);
        move("to01", -1, H);
        ph = 3;
        for (int k = 0; k < H; k++) do_sample("jump01_10", 2'b10, 1'b0, 0, 0, k == H - 1);
        check_val("jump01_10.err", 32'(bus.err), 1);
        do_sample("err_clr", 2'b10, 1'b0, 0, 0, 1);
        check_val("err_clr.err", 32'(bus.err), 0);

        // Index edge with forward step and idx_clr at count 5.
        do_sample("clr1", ab_of(ph), 1'b0, 1, 0, 0);
        for (int s = 0; s < 5; s++) move("to5", 1, H);
        ph = (ph + 1) % 4;
        for (int k = 0; k < H; k++) do_sample("idx_step", ab_of(ph), 1'b1, 0, k == H - 1, 0);
        check_val("idx_step.idx_pos", 32'(bus.idx_pos), 5);
        check_val("idx_step.idx_flag", 32'(bus.idx_flag), 1);
        check_val("idx_step.count", 32'(bus.count), 6);
        for (int k = 0; k < H; k++) do_sample("idx_low", ab_of(ph), 1'b0, 0, 0, 0);

        // clr beats a coincident forward step at count 20.
        do_sample("clr2", ab_of(ph), 1'b0, 1, 0, 0);
        for (int s = 0; s < 20; s++) move("to20", 1, H);
        check_val("to20.count", 32'(bus.count), 20);
        ph = (ph + 1) % 4;
        for (int k = 0; k < H; k++) do_sample("clr_step", ab_of(ph), 1'b0, k == H - 1, 0, 0);
        check_val("clr_step.count", 32'(bus.count), 0);
        check_val("clr_step.idx_pos", 32'(bus.idx_pos), 5);
        check_val("clr_step.err", 32'(bus.err), 0);

`ifdef QUAD_ENC_FILTER_EN
        // Two-sample glitch is rejected; three-sample change counts once.
        do_sample("glitch", ab_of(ph + 1), 1'b0, 0, 0, 0);
        do_sample("glitch", ab_of(ph + 1), 1'b0, 0, 0, 0);
        do_sample("glitch", ab_of(ph), 1'b0, 0, 0, 0);
        check_val("glitch.count", 32'(bus.count), 0);
        move("hold3", 1, 3);
        check_val("hold3.count", 32'(bus.count), 1);
        do_sample("hold4", ab_of(ph), 1'b0, 0, 0, 0);
        check_val("hold4.count", 32'(bus.count), 1);
`endif

        // Reset during a pending transition; re-prime before counting.
        ph = (ph + 1) % 4;
        bus.a = ab_of(ph)[1]; bus.b = ab_of(ph)[0];
        @(negedge clk);
        @(negedge clk);
        bus.en = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        bus.en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        compare_all("rst_mid");
        do_sample("reprime", ab_of(ph), 1'b0, 0, 0, 0);
        check_val("reprime.count", 32'(bus.count), 0);
        move("after_rst", 1, H);
        check_val("after_rst.count", 32'(bus.count), 1);

`ifndef QUAD_ENC_FILTER_EN
        // Fast forward to 0x7FFF with one step per clk, then one more step.
        do_sample("clr3", ab_of(ph), 1'b0, 1, 0, 0);
        bus.en = 1'b1;
        for (int s = 0; s < 32767; s++) begin
            ph = (ph + 1) % 4;
            bus.a = ab_of(ph)[1]; bus.b = ab_of(ph)[0];
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        bus.en = 1'b0;
        m_count = 32'h7FFF;
        m_ab = ab_of(ph);
        check_val("preset.count", 32'(bus.count), 32'h7FFF);
        move("pos_wrap", 1, 1);
        check_val("pos_wrap.count", 32'(bus.count), 32'h8000);
`endif

        // Random walk with occasional jumps, index pulses and clears.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 40) ph = (ph + 1) % 4;
            else if (r < 80) ph = (ph + 3) % 4;
            else if (r < 88) ph = (ph + 2) % 4;
            do_sample("rand", ab_of(ph), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/quad_enc.md
QUAD_ENC -- requirements
Module: quad_enc

Interface
REQ-001 Parameter W, default 16: width of position count and index latch.
REQ-002 Parameter FLT, default 3: consecutive stable samples required by the input filter (range 1-15).
REQ-003 clk  input  1  system clock, shared with the SPI/stepgen logic.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 en  input  1  sample strobe, one clk wide (driven from the divider strobe).
REQ-006 a, b  input  1 each  raw quadrature phases, asynchronous to clk.
REQ-007 idx  input  1  raw index pulse, asynchronous, active-high.
REQ-008 clr  input  1  one-clk pulse from the SPI decode; zeroes count.
REQ-009 idx_clr  input  1  one-clk pulse; clears idx_flag.
REQ-010 err_clr  input  1  one-clk pulse; clears err.
REQ-011 count  output  W  signed two's-complement position, read over SPI.
REQ-012 idx_pos  output  W  count captured at the last index edge.
REQ-013 idx_flag  output  1  sticky: index captured since last idx_clr.
REQ-014 err  output  1  sticky: illegal quadrature transition seen.

Function
REQ-015 a, b, idx SHALL each pass through a 2-flop synchronizer clocked every clk, independent of en.
REQ-016 Decode, filter and index logic SHALL advance only on clk cycles with en=1; with en=0 all state holds.
REQ-017 Filtered state {A,B} SHALL be compared with the previous filtered state on each en sample.
REQ-018 Transitions 00->01, 01->11, 11->10, 10->00 SHALL increment count by 1; the reverse four SHALL decrement by 1.
REQ-019 Unchanged state: count holds; both bits changed: count holds and err SHALL be set.
REQ-020 Count SHALL wrap modulo 2^W (0x7FFF +1 -> 0x8000; 0x0000 -1 -> 0xFFFF for W=16).
REQ-021 count SHALL update on the clk edge ending the en sample that detects the transition (1 clk after that sample).
REQ-022 Rising edge of filtered idx SHALL load idx_pos with the pre-update count of that sample and set idx_flag.
REQ-023 clr and a count transition in the same cycle: clr wins, count = 0.
REQ-024 idx_clr coincident with a new index edge: set wins, idx_flag = 1, idx_pos updated.
REQ-025 err_clr coincident with a new illegal transition: set wins, err = 1.
REQ-026 A primed bit SHALL be cleared by reset; the first en sample after reset loads previous state from the inputs without counting or flagging, then sets primed.
REQ-027 clr SHALL NOT affect idx_pos, idx_flag, err or primed.

Reset
REQ-028 On rst_n low, asynchronously: count=0, idx_pos=0, idx_flag=0, err=0, primed=0, synchronizers=0, filter counters=0.
REQ-029 Reset asserted mid-transition SHALL discard the pending sample; no count change after release until priming completes.

Configuration
REQ-030 Macro QUAD_ENC_FILTER_EN: when defined, each of A, B, idx SHALL change its filtered value only after the synchronized input differs from it on FLT consecutive en samples; a differing-then-equal sample resets its counter.
REQ-031 Without QUAD_ENC_FILTER_EN, filtered values SHALL equal synchronized values sampled at en (no counters synthesized).

Verification
REQ-032 Reset, prime with a=b=0, then 8 forward steps 00-01-11-10-00 held 4 en samples each -> count = 8, err = 0.
REQ-033 count preset to 0x7FFF via forward steps, one more forward step -> count = 0x8000; from 0 one reverse step -> 0xFFFF.
REQ-034 Jump a,b 00->11 in one sample -> count unchanged, err = 1; err_clr together with another 01->10 jump -> err stays 1.
REQ-035 Count at 5, idx pulse coincident with a forward step and idx_clr -> idx_pos = 5, idx_flag = 1, count = 6.
REQ-036 clr coincident with a forward step at count 20 -> count = 0 next clk; idx_pos/err unchanged.
REQ-037 With QUAD_ENC_FILTER_EN, FLT=3: a glitch held 2 en samples -> no count; held 3 samples -> count +1 exactly once.
